clk_div_mc: RTL

CLK_DIV_MC -- requirements
Module: clk_div_mc

---
 rtl/clk_div_mc_pkg.sv | 15 +
 rtl/clk_div_ch.sv | 96 +++++++++
 rtl/clk_div_mc.sv | 42 ++++
 3 files changed

// File: rtl/clk_div_mc_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_mc_pkg;

  localparam int RATIO_W_DEF = 8;
  // Ratios at or below this value pass the reference clock straight through
  localparam int BYPASS_MAX = 1;

  typedef logic [RATIO_W_DEF-1:0] ratio_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: posedge period counter, negedge half-cycle stretch for odd ratios,
// bypass for ratios 0/1. Optional o_tick under CLK_DIV_MC_TICK_EN.
module clk_div_ch
  import clk_div_mc_pkg::*;
#(
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int RST_RATIO = 2
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  input  logic               i_ratio_ld,
  output logic               o_div_clk,
  output logic               o_ratio_ack
`ifdef CLK_DIV_MC_TICK_EN
  ,
  output logic               o_tick
`endif
);

  ch_state_t          state_q, state_d;
  logic [RATIO_W-1:0] n_q, p_q, cnt_q;
  logic               pend_q, ack_q, pos_hi, neg_hi;
  logic               running, bypass, last, boundary;
  logic [RATIO_W:0]   half;

  assign running  = (state_q == CH_RUN);
  assign bypass   = (n_q <= RATIO_W'(BYPASS_MAX));
  assign last     = (cnt_q == n_q - RATIO_W'(1));
  // Idle and bypass channels accept a new ratio on any cycle
  assign boundary = !running || bypass || last;
  assign half     = ({1'b0, n_q} + (RATIO_W+1)'(1)) >> 1;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= CH_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) state_d = i_clk_en ? CH_RUN : CH_IDLE;
  end

  always_comb begin
    o_div_clk = 1'b0;
    if (bypass)        o_div_clk = running & i_ref_clk;
    else if (n_q[0])   o_div_clk = pos_hi & neg_hi;
    else               o_div_clk = pos_hi;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_q    <= RATIO_W'(RST_RATIO);
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      pos_hi <= 1'b0;
    end else begin
      pos_hi <= running && !bypass && ({1'b0, cnt_q} < half);
      ack_q  <= 1'b0;
      if (boundary) begin
        cnt_q <= '0;
        // A strobe landing on the boundary wins over any older pending value
        if (i_ratio_ld) begin
          n_q    <= i_div_ratio;
          pend_q <= 1'b0;
          ack_q  <= 1'b1;
        end else if (pend_q) begin
          n_q    <= p_q;
          pend_q <= 1'b0;
          ack_q  <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + RATIO_W'(1);
        if (i_ratio_ld) pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_ratio_ld && !boundary) p_q <= i_div_ratio;
  end

  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) neg_hi <= 1'b0;
    else          neg_hi <= pos_hi;
  end

  assign o_ratio_ack = ack_q;

`ifdef CLK_DIV_MC_TICK_EN
  assign o_tick = running && !bypass && (cnt_q == '0);
`endif

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel 50%-duty clock divider with glitch-free ratio reload.
// Define CLK_DIV_MC_TICK_EN to add the per-channel o_tick period-start pulse.
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int RATIO_W   = RATIO_W_DEF,
  parameter int RST_RATIO = 2
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_CH-1:0]         i_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]         i_ratio_ld,
  output logic [NUM_CH-1:0]         o_div_clk,
  output logic [NUM_CH-1:0]         o_ratio_ack
`ifdef CLK_DIV_MC_TICK_EN
  ,
  output logic [NUM_CH-1:0]         o_tick
`endif
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .RATIO_W  (RATIO_W),
      .RST_RATIO(RST_RATIO)
    ) u_ch (
      .i_ref_clk  (i_ref_clk),
      .i_rst_n    (i_rst_n),
      .i_clk_en   (i_clk_en[c]),
      .i_div_ratio(i_div_ratio[c*RATIO_W +: RATIO_W]),
      .i_ratio_ld (i_ratio_ld[c]),
      .o_div_clk  (o_div_clk[c]),
      .o_ratio_ack(o_ratio_ack[c])
`ifdef CLK_DIV_MC_TICK_EN
      ,
      .o_tick     (o_tick[c])
`endif
    );
  end

endmodule
